serial_parity_rx: RTL and testbench
===================================

// Module: serial_parity_rx
// PURPOSE
//   Serial frame receiver with parity check; receiving end of the parity-protected serial link.
//   - Frame: start bit (0), DATA_W data bits LSB first, one parity bit, stop bit (1).
//   - Parity is accumulated with the team's gate-level XOR/XNOR primitives.
//   - Delivers the deserialized word with parity-error and framing-error flags
//     to the downstream datapath or display logic.
// PARAMETERS
//   DATA_W      8   number of data bits per frame (1..16)
//   PARITY_ODD  0   0 = even parity expected, 1 = odd parity expected
// PORTS
//   clk         in   1       single system clock, rising edge
//   rst         in   1       synchronous, active-high reset
//   bit_en      in   1       bit-time strobe; rx is sampled only in cycles where bit_en=1
//   rx          in   1       serial line, idle high
//   data_out    out  DATA_W  last received word; held until the next frame completes
//   data_valid  out  1       one-cycle pulse: frame complete, data_out/flags updated
//   parity_err  out  1       qualifies data_valid; parity mismatch in the completed frame
//   frame_err   out  1       qualifies data_valid; stop bit sampled as 0
//   busy        out  1       1 while a frame is in progress (state != IDLE)
// BEHAVIOUR
//   Interface
//   - One clock (clk); reset rst is synchronous and active-high.
//   - Reset: state=IDLE, bit counter=0, parity accumulator=0.
//   - Reset values: data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
//   FSM (advances only on bit_en=1; all registers hold when bit_en=0)
//   - IDLE: rx=0 -> DATA, cnt=0, acc=0. rx=1 -> stay in IDLE.
//   - DATA: shift rx into sreg[cnt], acc <= acc ^ rx, cnt++.
//     After bit DATA_W-1 is sampled -> PARITY.
//   - PARITY: latch perr = (acc ^ rx) != PARITY_ODD -> STOP.
//   - STOP: data_out <= sreg, parity_err <= perr, frame_err <= ~rx, data_valid <= 1 -> IDLE.
//   Outputs and timing
//   - data_valid is high for exactly one cycle: the cycle after the edge that sampled the stop bit.
//   - It is never asserted in any other case.
//   - parity_err and frame_err are registered with data_out and hold until the next completed frame.
//   - data_out is also updated on error frames.
//   - busy = (state != IDLE). It is registered and falls on the same edge that raises data_valid.
//   Boundary cases
//   - Back-to-back frames: a start bit on the first bit_en after STOP is accepted. No idle bit is required.
//   - Glitch at start: no mid-bit re-check. A start bit is committed on a single sample.
//   - Reset mid-frame: frame aborts, no data_valid, all outputs return to reset values.
//   - bit_en held high continuously: one bit per clock, legal.
//   - rx is assumed synchronous to clk. The caller supplies any external synchronizer.
// STRUCTURE
//   Package serial_parity_pkg
//   - FSM state encoding: IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3.
//   - Frame constants: START_BIT=1'b0, STOP_BIT=1'b1.
//   Sub-module parity_xnor_acc
//   - 1-bit registered accumulator (clr, en, d -> acc).
//   - Built from the gate-level xor/xnor primitives.
//   - Reused later by the matching transmitter.
//   Top-level contents
//   - FSM, counter of width $clog2(DATA_W+1), shift register, output registers.
// TESTING  (DATA_W=8, PARITY_ODD=0, bit_en every cycle unless stated)
//   1. Frame 0xA5, parity 0, stop 1
//      -> data_out=8'hA5, data_valid pulses 1 cycle, parity_err=0, frame_err=0.
//   2. Frame 0xA5, parity 1, stop 1
//      -> data_out=8'hA5, data_valid=1, parity_err=1, frame_err=0.
//   3. Frame 0x3C, parity 0, stop 0
//      -> data_out=8'h3C, data_valid=1, parity_err=0, frame_err=1.
//   4. rst=1 for 1 cycle after 3 data bits of 0x5A
//      -> no data_valid, busy=0, all outputs zero.
//      Then a clean 0x5A frame -> data_out=8'h5A, no errors.
//   5. Frame 0xC3 with bit_en high 1 cycle in 4 (3 idle cycles between bits)
//      -> identical result to continuous bit_en. No state change on bit_en=0 cycles.
//   6. Back-to-back frames 0x00 (par 0) then 0xFF (par 0) with no idle bit
//      -> two data_valid pulses, 8'h00 then 8'hFF, no errors.
//   7. PARITY_ODD=1 build, frame 0x01 with parity 0 -> parity_err=0.
//      Same frame with parity 1 -> parity_err=1.

Source files
------------

// File: rtl/serial_parity_pkg.sv
// Shared definitions for the parity-protected serial link:
// FSM state encoding and frame bit constants.
package serial_parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/parity_xnor_acc.sv
// 1-bit registered XOR parity accumulator built from gate primitives.
// Ports: clk, rst (sync, active-high), clr, en, d -> acc, sum (= acc ^ d).
module parity_xnor_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic acc,
    output logic sum
);

    logic r_acc;
    logic w_sum;

    xor u_xor (w_sum, r_acc, d);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_acc <= 1'b0;
        end else if (en) begin
            r_acc <= w_sum;
        end
    end

    assign acc = r_acc;
    assign sum = w_sum;

endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Ports: clk, rst, bit_en, rx -> data_out, data_valid, parity_err,
//        frame_err, busy.
module serial_parity_rx
    import serial_parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              rx,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W + 1);

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_sreg;
    logic              r_perr;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_perr_o;
    logic              r_ferr;
    logic              r_busy;

    logic [DATA_W-1:0] w_sreg_nxt;
    logic              w_clr;
    logic              w_acc_en;
    logic              w_acc;
    logic              w_sum;
    logic              w_exp_n;
    logic              w_perr;
    logic              w_last;

    assign w_clr    = bit_en && (r_state == IDLE) && (rx == START_BIT);
    assign w_acc_en = bit_en && (r_state == DATA);
    assign w_last   = (r_cnt == CW'(DATA_W - 1));

    parity_xnor_acc u_acc (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .en  (w_acc_en),
        .d   (rx),
        .acc (w_acc),
        .sum (w_sum)
    );

    // xnor(sum, ~odd) == sum ^ odd: high when parity disagrees
    assign w_exp_n = ~PARITY_ODD;
    xnor u_chk (w_perr, w_sum, w_exp_n);

    // Place the current data bit at position r_cnt
    always_comb begin
        w_sreg_nxt = r_sreg;
        for (int i = 0; i < DATA_W; i++) begin
            if (CW'(i) == r_cnt) begin
                w_sreg_nxt[i] = rx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_sreg   <= '0;
            r_perr   <= 1'b0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_perr_o <= 1'b0;
            r_ferr   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (bit_en) begin
                unique case (r_state)
                    IDLE: begin
                        if (rx == START_BIT) begin
                            r_state <= DATA;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    DATA: begin
                        r_sreg <= w_sreg_nxt;
                        r_cnt  <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        r_perr  <= w_perr;
                        r_state <= STOP;
                    end
                    STOP: begin
                        r_data   <= r_sreg;
                        r_perr_o <= r_perr;
                        r_ferr   <= (rx != STOP_BIT);
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign data_out   = r_data;
    assign data_valid = r_valid;
    assign parity_err = r_perr_o;
    assign frame_err  = r_ferr;
    assign busy       = r_busy;

    logic w_unused;
    assign w_unused = w_acc;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed testbench for serial_parity_rx (even and odd parity builds).
// Frames are driven on negedge; outputs are checked after the negedge.
module tb_serial_parity_rx;

    logic       clk;
    logic       rst;
    logic       bit_en;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;
    logic [7:0] o_data_out;
    logic       o_data_valid;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] q_ev[$];
    logic [9:0] q_od[$];

    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) u_odd (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .rx         (rx),
        .data_out   (o_data_out),
        .data_valid (o_data_valid),
        .parity_err (o_parity_err),
        .frame_err  (o_frame_err),
        .busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid)
            q_ev.push_back({parity_err, frame_err, data_out});
        if (o_data_valid)
            q_od.push_back({o_parity_err, o_frame_err, o_data_out});
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int gap);
        @(negedge clk);
        rx = b;
        bit_en = 1'b1;
        repeat (gap) begin
            @(negedge clk);
            bit_en = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic s, input int gap);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) send_bit(d[i], gap);
        send_bit(p, gap);
        send_bit(s, 0);
    endtask

    task automatic finish_frame();
        @(negedge clk);
        rx = 1'b1;
        bit_en = 1'b0;
        #1;
    endtask

    task automatic expect_ev(input string tag, input logic [7:0] d,
                             input logic pe, input logic fe);
        logic [9:0] v;
        if (q_ev.size() == 0) begin
            chk({tag, "_pulse"}, 32'd0, 32'd1);
        end else begin
            v = q_ev.pop_front();
            chk(tag, {22'd0, v}, {22'd0, pe, fe, d});
        end
    endtask

    task automatic expect_od(input string tag, input logic [7:0] d,
                             input logic pe, input logic fe);
        logic [9:0] v;
        if (q_od.size() == 0) begin
            chk({tag, "_pulse"}, 32'd0, 32'd1);
        end else begin
            v = q_od.pop_front();
            chk(tag, {22'd0, v}, {22'd0, pe, fe, d});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not end");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bit_en = 1'b0;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_flags", {27'd0, data_valid, parity_err, frame_err, busy,
            1'b0}, 32'd0);

        // 1: clean frame, one-cycle pulse
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        finish_frame();
        chk("t1_dv", {31'd0, data_valid}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        expect_ev("t1_frame", 8'hA5, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("t1_dv_low", {31'd0, data_valid}, 32'd0);
        chk("t1_hold", {24'd0, data_out}, 32'h0000_00A5);

        // 2: parity error
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        finish_frame();
        expect_ev("t2_frame", 8'hA5, 1'b1, 1'b0);

        // 3: framing error
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        finish_frame();
        expect_ev("t3_frame", 8'h3C, 1'b0, 1'b1);
        chk("t3_none", q_ev.size(), 32'd0);

        // 4: reset mid-frame
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        @(negedge clk);
        chk("t4_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        bit_en = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_data", {24'd0, data_out}, 32'd0);
        chk("t4_flags", {29'd0, data_valid, parity_err, frame_err}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t4_nopulse", q_ev.size(), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1, 0);
        finish_frame();
        expect_ev("t4_frame", 8'h5A, 1'b0, 1'b0);

        // 5: bit_en one cycle in four
        send_frame(8'hC3, 1'b0, 1'b1, 3);
        #1;
        chk("t5_busy", {31'd0, busy}, 32'd1);
        finish_frame();
        chk("t5_dv", {31'd0, data_valid}, 32'd1);
        expect_ev("t5_frame", 8'hC3, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("t5_single", q_ev.size(), 32'd0);

        // 6: back-to-back frames
        send_frame(8'h00, 1'b0, 1'b1, 0);
        send_frame(8'hFF, 1'b0, 1'b1, 0);
        finish_frame();
        expect_ev("t6_first", 8'h00, 1'b0, 1'b0);
        expect_ev("t6_second", 8'hFF, 1'b0, 1'b0);
        chk("t6_count", q_ev.size(), 32'd0);

        // 7: odd vs even parity builds
        q_od.delete();
        send_frame(8'h01, 1'b0, 1'b1, 0);
        finish_frame();
        expect_od("t7_odd_p0", 8'h01, 1'b0, 1'b0);
        expect_ev("t7_even_p0", 8'h01, 1'b1, 1'b0);
        send_frame(8'h01, 1'b1, 1'b1, 0);
        finish_frame();
        expect_od("t7_odd_p1", 8'h01, 1'b1, 1'b0);
        expect_ev("t7_even_p1", 8'h01, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("end_quiet", q_ev.size() + q_od.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
